// File: rtl/move_buffer_pkg.sv
// move_buffer_pkg: shared constants and segment layout for the move buffer.
//   MOVE_BUFFER_BITS : default log2 entry count
//   SEG_DATA_W       : default width of duration / increment / incrinc fields
//   segment_t        : packed {dir, duration, increment, incrinc} at default width
//   seg_width()      : segment width for an arbitrary field width (1 + 3*data_w)
package move_buffer_pkg;

    localparam int unsigned MOVE_BUFFER_BITS = 2;
    localparam int unsigned SEG_DATA_W       = 64;

    typedef struct packed {
        logic                  dir;
        logic [SEG_DATA_W-1:0] duration;
        logic [SEG_DATA_W-1:0] increment;
        logic [SEG_DATA_W-1:0] incrinc;
    } segment_t;

    function automatic int unsigned seg_width(input int unsigned data_w);
        return 1 + 3 * data_w;
    endfunction

endpackage

// File: rtl/move_buffer_if.sv
// move_buffer_if: write/read handshake bundle of the move buffer.
//   master : producer/consumer side (SPI handler + timing engine, or a bench)
//   slave  : the buffer itself
// Signals: flush, wr_valid/wr_ready/wr_reject + wr_* fields, rd_valid/rd_ready + rd_* fields,
//          count (occupancy), underrun (sticky starvation flag).
interface move_buffer_if
    import move_buffer_pkg::*;
#(
    parameter int unsigned DEPTH_BITS = MOVE_BUFFER_BITS,
    parameter int unsigned DATA_W     = SEG_DATA_W
);

    logic                  flush;
    logic                  wr_valid;
    logic                  wr_ready;
    logic                  wr_dir;
    logic [DATA_W-1:0]     wr_duration;
    logic [DATA_W-1:0]     wr_increment;
    logic [DATA_W-1:0]     wr_incrinc;
    logic                  wr_reject;
    logic                  rd_valid;
    logic                  rd_ready;
    logic                  rd_dir;
    logic [DATA_W-1:0]     rd_duration;
    logic [DATA_W-1:0]     rd_increment;
    logic [DATA_W-1:0]     rd_incrinc;
    logic [DEPTH_BITS:0]   count;
    logic                  underrun;

    modport master (
        output flush, wr_valid, wr_dir, wr_duration, wr_increment, wr_incrinc, rd_ready,
        input  wr_ready, wr_reject, rd_valid, rd_dir, rd_duration, rd_increment, rd_incrinc,
        input  count, underrun
    );

    modport slave (
        input  flush, wr_valid, wr_dir, wr_duration, wr_increment, wr_incrinc, rd_ready,
        output wr_ready, wr_reject, rd_valid, rd_dir, rd_duration, rd_increment, rd_incrinc,
        output count, underrun
    );

endinterface

// File: rtl/move_buffer_mem.sv
// move_buffer_mem: simple dual-port register array, one write port, one read port.
//   clk   : clock
//   we    : write enable, stores wdata at waddr on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read of registered contents)
//   rdata : read data
// Contents are not reset; the parent masks reads while empty.
module move_buffer_mem #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned WIDTH  = 193
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [1 << ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/move_buffer.sv
// move_buffer: queue of coordinated-move segments between the SPI handler and the
// stepper timing engine.
//   clk    : system clock
//   resetn : synchronous active-low reset
//   bus    : move_buffer_if.slave (flush, wr_* push side, rd_* pop side, count, underrun)
// Zero-duration segments are consumed but dropped, with a one-cycle wr_reject pulse.
// Optional feature macro: MOVE_BUFFER_UNDERRUN_EN builds the sticky underrun flag;
// without it underrun is tied low.
module move_buffer
    import move_buffer_pkg::*;
#(
    parameter int unsigned DEPTH_BITS = MOVE_BUFFER_BITS,
    parameter int unsigned DATA_W     = SEG_DATA_W
) (
    input  logic         clk,
    input  logic         resetn,
    move_buffer_if.slave bus
);

    localparam int unsigned SEG_W = seg_width(DATA_W);
    localparam logic [DEPTH_BITS:0] DEPTH_CNT = {1'b1, {DEPTH_BITS{1'b0}}};

    logic [DEPTH_BITS-1:0] wp_q, wp_d;
    logic [DEPTH_BITS-1:0] rp_q, rp_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic                  wr_reject_q, wr_reject_d;

    logic wr_ready;
    logic rd_valid;
    logic accept;
    logic push;
    logic pop;

    logic [SEG_W-1:0] wr_seg;
    logic [SEG_W-1:0] rd_seg_raw;
    logic [SEG_W-1:0] rd_seg;

    // Flags come from registered count only, so no input reaches an output combinationally.
    assign wr_ready = (count_q != DEPTH_CNT);
    assign rd_valid = (count_q != '0);
    assign accept   = bus.wr_valid && wr_ready;
    assign push     = accept && (bus.wr_duration != '0);
    assign pop      = rd_valid && bus.rd_ready;

    assign wr_seg = {bus.wr_dir, bus.wr_duration, bus.wr_increment, bus.wr_incrinc};

    always_comb begin
        wp_d        = wp_q;
        rp_d        = rp_q;
        count_d     = count_q;
        wr_reject_d = accept && (bus.wr_duration == '0);
        if (bus.flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wp_d = wp_q + DEPTH_BITS'(1);
            end
            if (pop) begin
                rp_d = rp_q + DEPTH_BITS'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + (DEPTH_BITS + 1)'(1);
                2'b01:   count_d = count_q - (DEPTH_BITS + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            wr_reject_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            wr_reject_q <= wr_reject_d;
        end
    end

    move_buffer_mem #(
        .ADDR_W (DEPTH_BITS),
        .WIDTH  (SEG_W)
    ) u_mem (
        .clk   (clk),
        .we    (push && !bus.flush),
        .waddr (wp_q),
        .wdata (wr_seg),
        .raddr (rp_q),
        .rdata (rd_seg_raw)
    );

    // Storage is never cleared, so mask the head while empty to give zero rd_* after reset.
    assign rd_seg = rd_valid ? rd_seg_raw : '0;

    assign {bus.rd_dir, bus.rd_duration, bus.rd_increment, bus.rd_incrinc} = rd_seg;

    assign bus.wr_ready  = wr_ready;
    assign bus.rd_valid  = rd_valid;
    assign bus.count     = count_q;
    assign bus.wr_reject = wr_reject_q;

`ifdef MOVE_BUFFER_UNDERRUN_EN
    logic armed_q;
    logic underrun_q;

    // Armed by the first pop so an idle, never-started engine polling rd_ready is not flagged.
    always_ff @(posedge clk) begin
        if (!resetn || bus.flush) begin
            armed_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (pop) begin
                armed_q <= 1'b1;
            end
            if (armed_q && bus.rd_ready && !rd_valid) begin
                underrun_q <= 1'b1;
            end
        end
    end

    assign bus.underrun = underrun_q;
`else
    assign bus.underrun = 1'b0;
`endif

endmodule

// File: tb/tb_move_buffer.sv
// tb_move_buffer: directed self-checking bench for move_buffer.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
module tb_move_buffer;

    logic clk;
    logic resetn;

    move_buffer_if bus ();

    move_buffer dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

`ifdef MOVE_BUFFER_UNDERRUN_EN
    localparam logic UNDERRUN_EXP = 1'b1;
`else
    localparam logic UNDERRUN_EXP = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] dur);
        bus.wr_valid    = 1'b1;
        bus.wr_dir      = 1'b0;
        bus.wr_duration = dur;
        bus.wr_increment = dur + 64'd1000;
        bus.wr_incrinc  = '0;
        step();
        bus.wr_valid    = 1'b0;
    endtask

    task automatic pop_one();
        bus.rd_ready = 1'b1;
        step();
        bus.rd_ready = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        resetn           = 1'b0;
        bus.flush        = 1'b0;
        bus.wr_valid     = 1'b0;
        bus.wr_dir       = 1'b0;
        bus.wr_duration  = '0;
        bus.wr_increment = '0;
        bus.wr_incrinc   = '0;
        bus.rd_ready     = 1'b0;
        step();
        step();
        resetn = 1'b1;

        // Reset state
        check("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
        check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_wr_reject", 64'(bus.wr_reject), 64'd0);
        check("rst_underrun", 64'(bus.underrun), 64'd0);
        check("rst_rd_duration", bus.rd_duration, 64'd0);
        check("rst_rd_increment", bus.rd_increment, 64'd0);

        // Single push, visible next cycle
        bus.wr_valid     = 1'b1;
        bus.wr_dir       = 1'b1;
        bus.wr_duration  = 64'd100;
        bus.wr_increment = 64'd5;
        bus.wr_incrinc   = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        bus.wr_valid = 1'b0;
        check("p1_rd_valid", 64'(bus.rd_valid), 64'd1);
        check("p1_rd_dir", 64'(bus.rd_dir), 64'd1);
        check("p1_rd_duration", bus.rd_duration, 64'd100);
        check("p1_rd_increment", bus.rd_increment, 64'd5);
        check("p1_rd_incrinc", bus.rd_incrinc, 64'hFFFF_FFFF_FFFF_FFFF);
        check("p1_count", 64'(bus.count), 64'd1);
        pop_one();
        check("p1_pop_count", 64'(bus.count), 64'd0);
        check("p1_pop_rd_valid", 64'(bus.rd_valid), 64'd0);

        // Fill to full, refused 5th push
        for (int i = 1; i <= 4; i++) push(64'(i));
        check("full_wr_ready", 64'(bus.wr_ready), 64'd0);
        check("full_count", 64'(bus.count), 64'd4);
        bus.wr_valid    = 1'b1;
        bus.wr_duration = 64'd5;
        step();
        step();
        bus.wr_valid = 1'b0;
        check("full_hold_count", 64'(bus.count), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("full_pop%0d_dur", i), bus.rd_duration, 64'(i));
            check($sformatf("full_pop%0d_inc", i), bus.rd_increment, 64'(i + 1000));
            pop_one();
        end
        check("full_drain_count", 64'(bus.count), 64'd0);
        check("full_drain_rd_valid", 64'(bus.rd_valid), 64'd0);

        // Full: push refused even with a simultaneous pop
        for (int i = 21; i <= 24; i++) push(64'(i));
        bus.wr_valid    = 1'b1;
        bus.wr_duration = 64'd25;
        bus.rd_ready    = 1'b1;
        step();
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        check("fullpop_count", 64'(bus.count), 64'd3);
        for (int i = 22; i <= 24; i++) begin
            check($sformatf("fullpop_dur%0d", i), bus.rd_duration, 64'(i));
            pop_one();
        end
        check("fullpop_empty", 64'(bus.rd_valid), 64'd0);

        // Simultaneous push/pop at count 2
        push(64'd8);
        push(64'd9);
        check("sim_pre_count", 64'(bus.count), 64'd2);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("sim%0d_head", i), bus.rd_duration, 64'(8 + i));
            bus.wr_valid    = 1'b1;
            bus.wr_duration = 64'(10 + i);
            bus.rd_ready    = 1'b1;
            step();
            check($sformatf("sim%0d_count", i), 64'(bus.count), 64'd2);
        end
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        check("sim_tail0", bus.rd_duration, 64'd18);
        pop_one();
        check("sim_tail1", bus.rd_duration, 64'd19);
        pop_one();
        check("sim_end_count", 64'(bus.count), 64'd0);

        // Zero-duration reject
        push(64'd0);
        check("rej_pulse", 64'(bus.wr_reject), 64'd1);
        check("rej_count", 64'(bus.count), 64'd0);
        check("rej_wr_ready", 64'(bus.wr_ready), 64'd1);
        check("rej_rd_valid", 64'(bus.rd_valid), 64'd0);
        step();
        check("rej_pulse_end", 64'(bus.wr_reject), 64'd0);

        // Flush beats push and pop in the same cycle
        for (int i = 31; i <= 33; i++) push(64'(i));
        check("fl_pre_count", 64'(bus.count), 64'd3);
        bus.flush       = 1'b1;
        bus.wr_valid    = 1'b1;
        bus.wr_duration = 64'd34;
        bus.rd_ready    = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        check("fl_count", 64'(bus.count), 64'd0);
        check("fl_rd_valid", 64'(bus.rd_valid), 64'd0);
        push(64'd7);
        check("fl_after_dur", bus.rd_duration, 64'd7);
        check("fl_after_count", 64'(bus.count), 64'd1);
        pop_one();

        // Reset mid-operation discards entries
        push(64'd41);
        push(64'd42);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check("mrst_count", 64'(bus.count), 64'd0);
        check("mrst_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("mrst_wr_ready", 64'(bus.wr_ready), 64'd1);

        // Underrun: arm by pop, then starve
        push(64'd50);
        bus.rd_ready = 1'b1;
        step();
        check("ur_after_pop", 64'(bus.underrun), 64'd0);
        step();
        bus.rd_ready = 1'b0;
        check("ur_starved", 64'(bus.underrun), 64'(UNDERRUN_EXP));
        push(64'd51);
        check("ur_sticky", 64'(bus.underrun), 64'(UNDERRUN_EXP));
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("ur_flush", 64'(bus.underrun), 64'd0);
        check("ur_flush_count", 64'(bus.count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
